pa_core_exu_div_pipe: RTL and testbench

Parametrised iterative integer divider for the execute unit, successor to the fixed 32-bit, 33-cycle divider. It accepts a request through a valid/ready handshake and decodes all four RISC-V divide ops internally, including sign handling. It retires 1 or 2 quotient bits per cycle and holds the result under a valid/ready response handshake. It also supports pipeline flush and an optional fast path for trivial operands.

---
 rtl/pa_core_exu_div_pipe.sv | 143 ++++++++++++++
 tb/tb_pa_core_exu_div_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pa_core_exu_div_pipe.sv
// pa_core_exu_div_pipe: iterative restoring divider (DIV/DIVU/REM/REMU), 1 or 2 quotient bits per cycle.
// Optional trivial-operand fast path compiled in with `define PA_DIV_FAST_PATH_EN.
module pa_core_exu_div_pipe #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      req_vld_i,
   output logic                      req_rdy_o,
   input  logic [DATA_WIDTH-1:0]     data1_i,
   input  logic [DATA_WIDTH-1:0]     data2_i,
   input  logic [1:0]                op_i,
   input  logic [REG_ADDR_WIDTH-1:0] reg_waddr_i,
   input  logic                      flush_i,
   output logic                      busy_o,
   output logic                      rsp_vld_o,
   input  logic                      rsp_rdy_i,
   output logic [DATA_WIDTH-1:0]     data_o,
   output logic [REG_ADDR_WIDTH-1:0] reg_waddr_o
);
   localparam int W  = DATA_WIDTH;
   localparam int N  = W / BITS_PER_CYCLE;
   localparam int CW = $clog2(N);
   localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                    r_state;
   logic [2*W:0]              r_pr;
   logic [W-1:0]              r_dsr;
   logic [CW-1:0]             r_cnt;
   logic                      r_q_neg;
   logic                      r_r_neg;
   logic                      r_ovf;
   logic [1:0]                r_op;
   logic [REG_ADDR_WIDTH-1:0] r_waddr;
   logic [W-1:0]              r_data;

   logic          w_signed;
   logic          w_s1;
   logic          w_s2;
   logic [W-1:0]  w_abs1;
   logic [W-1:0]  w_abs2;
   logic          w_ovf;
   logic          w_fast;
   logic [W-1:0]  w_fast_res;
   logic [2*W:0]  w_pr;
   logic [W+1:0]  w_diff;
   logic [W-1:0]  w_sel;
   logic          w_neg;
   logic [W-1:0]  w_fix;
   logic [W-1:0]  w_res;

   assign w_signed = ~op_i[0];
   assign w_s1     = w_signed & data1_i[W-1];
   assign w_s2     = w_signed & data2_i[W-1];
   assign w_abs1   = w_s1 ? -data1_i : data1_i;
   assign w_abs2   = w_s2 ? -data2_i : data2_i;
   assign w_ovf    = w_signed & (data1_i == MIN) & (&data2_i);

`ifdef PA_DIV_FAST_PATH_EN
   logic w_div0;
   assign w_div0     = data2_i == '0;
   assign w_fast     = w_div0 | w_ovf | (w_abs2 > w_abs1);
   assign w_fast_res = w_div0 ? (op_i[1] ? data1_i : '1) :
                       w_ovf  ? (op_i[1] ? '0 : MIN) :
                                (op_i[1] ? data1_i : '0);
`else
   assign w_fast     = 1'b0;
   assign w_fast_res = '0;
`endif

   // BITS_PER_CYCLE restoring shift/trial-subtract steps on the partial remainder
   always_comb begin
      w_pr   = r_pr;
      w_diff = '0;
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
         w_pr   = w_pr << 1;
         w_diff = {1'b0, w_pr[2*W:W]} - {2'b00, r_dsr};
         if (!w_diff[W+1]) w_pr = {w_diff[W:0], w_pr[W-1:1], 1'b1};
      end
   end

   // divide-by-zero remainder (= raw dividend) falls out of the iteration plus sign fixup;
   // only its quotient and the signed-overflow case need the override
   assign w_sel = r_op[1] ? w_pr[2*W-1:W] : w_pr[W-1:0];
   assign w_neg = r_op[1] ? r_r_neg : r_q_neg;
   assign w_fix = w_neg ? -w_sel : w_sel;
   assign w_res = (r_dsr == '0 && !r_op[1]) ? '1 :
                  r_ovf ? (r_op[1] ? '0 : MIN) : w_fix;

   assign req_rdy_o   = (r_state == IDLE) & ~flush_i;
   assign busy_o      = r_state != IDLE;
   assign rsp_vld_o   = r_state == DONE;
   assign data_o      = r_data;
   assign reg_waddr_o = rsp_vld_o ? r_waddr : '0;

   // control FSM with operand latch, iteration and result register; flush beats accept and consume
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= IDLE;
         r_pr    <= '0;
         r_dsr   <= '0;
         r_cnt   <= '0;
         r_q_neg <= 1'b0;
         r_r_neg <= 1'b0;
         r_ovf   <= 1'b0;
         r_op    <= '0;
         r_waddr <= '0;
         r_data  <= '0;
      end else if (flush_i) begin
         r_state <= IDLE;
         r_data  <= '0;
      end else begin
         case (r_state)
            IDLE: if (req_vld_i) begin
               r_pr    <= {{(W+1){1'b0}}, w_abs1};
               r_dsr   <= w_abs2;
               r_cnt   <= '0;
               r_q_neg <= w_s1 ^ w_s2;
               r_r_neg <= w_s1;
               r_ovf   <= w_ovf;
               r_op    <= op_i;
               r_waddr <= reg_waddr_i;
               r_state <= w_fast ? DONE : CALC;
               if (w_fast) r_data <= w_fast_res;
            end
            CALC: begin
               r_pr  <= w_pr;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(N-1)) begin
                  r_state <= DONE;
                  r_data  <= w_res;
               end
            end
            DONE: if (rsp_rdy_i) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pa_core_exu_div_pipe.sv
// tb_pa_core_exu_div_pipe: directed checks for the divider, 32-bit/1-bit and 16-bit/2-bit builds.
module tb_pa_core_exu_div_pipe;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_vld = 1'b0, req_rdy, flush = 1'b0, busy, rsp_vld, rsp_rdy = 1'b0;
   logic [31:0] data1 = '0, data2 = '0, dout;
   logic [1:0]  op = '0;
   logic [4:0]  waddr = '0, waddr_o;
   logic        req_vld2 = 1'b0, req_rdy2, busy2, rsp_vld2, rsp_rdy2 = 1'b0;
   logic [15:0] data1_2 = '0, data2_2 = '0, dout2;
   logic [4:0]  waddr_o2;
   int          checks = 0, errors = 0;
`ifdef PA_DIV_FAST_PATH_EN
   localparam int FAST_LAT = 0;
`else
   localparam int FAST_LAT = 32;
`endif

   always #5 clk = ~clk;

   pa_core_exu_div_pipe u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .req_vld_i(req_vld), .req_rdy_o(req_rdy),
      .data1_i(data1), .data2_i(data2), .op_i(op), .reg_waddr_i(waddr),
      .flush_i(flush), .busy_o(busy), .rsp_vld_o(rsp_vld), .rsp_rdy_i(rsp_rdy),
      .data_o(dout), .reg_waddr_o(waddr_o)
   );

   pa_core_exu_div_pipe #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(5), .BITS_PER_CYCLE(2)) u_dut2 (
      .clk_i(clk), .rst_n_i(rst_n), .req_vld_i(req_vld2), .req_rdy_o(req_rdy2),
      .data1_i(data1_2), .data2_i(data2_2), .op_i(2'b01), .reg_waddr_i(5'd3),
      .flush_i(1'b0), .busy_o(busy2), .rsp_vld_o(rsp_vld2), .rsp_rdy_i(rsp_rdy2),
      .data_o(dout2), .reg_waddr_o(waddr_o2)
   );

   // issue one request, wait for the response, report result/latency, then consume it
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, output logic [31:0] res, output int lat,
                         output logic [4:0] wa_out);
      op = o; data1 = a; data2 = b; waddr = wa; req_vld = 1'b1; rsp_rdy = 1'b0;
      @(posedge clk); #1;
      req_vld = 1'b0;
      lat = 0;
      while (!rsp_vld && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      res = dout; wa_out = waddr_o;
      rsp_rdy = 1'b1;
      @(posedge clk); #1;
      rsp_rdy = 1'b0;
   endtask

   task automatic test_reset;
      checks++; if (req_rdy !== 1'b1) begin errors++; $display("FAIL reset_req_rdy got %b exp 1", req_rdy); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_rsp_vld got %b exp 0", rsp_vld); end
      checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", dout); end
      checks++; if (waddr_o !== 5'h0) begin errors++; $display("FAIL reset_waddr got %h exp 0", waddr_o); end
   endtask

   task automatic test_unsigned;
      logic [31:0] r; int l; logic [4:0] w;
      run_op(2'b01, 32'd100, 32'd7, 5'd5, r, l, w);
      checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_100_7 got %h exp %h", r, 32'd14); end
      checks++; if (l !== 32) begin errors++; $display("FAIL divu_latency got %0d exp 32", l); end
      checks++; if (w !== 5'd5) begin errors++; $display("FAIL divu_waddr got %h exp 5", w); end
      run_op(2'b11, 32'd100, 32'd7, 5'd6, r, l, w);
      checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_100_7 got %h exp 2", r); end
   endtask

   task automatic test_signed;
      logic [31:0] r; int l; logic [4:0] w;
      run_op(2'b00, -32'sd7, 32'd2, 5'd1, r, l, w);
      checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2 got %h exp FFFFFFFD", r); end
      run_op(2'b10, -32'sd7, 32'd2, 5'd1, r, l, w);
      checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2 got %h exp FFFFFFFF", r); end
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, r, l, w);
      checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf got %h exp 80000000", r); end
      checks++; if (l !== FAST_LAT) begin errors++; $display("FAIL div_ovf_latency got %0d exp %0d", l, FAST_LAT); end
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, r, l, w);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL rem_ovf got %h exp 0", r); end
      run_op(2'b00, 32'd100, -32'sd7, 5'd2, r, l, w);
      checks++; if (r !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_100_m7 got %h exp FFFFFFF2", r); end
   endtask

   task automatic test_special;
      logic [31:0] r; int l; logic [4:0] w;
      run_op(2'b01, 32'd5, 32'd0, 5'd7, r, l, w);
      checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_5_0 got %h exp FFFFFFFF", r); end
      checks++; if (l !== FAST_LAT) begin errors++; $display("FAIL div0_latency got %0d exp %0d", l, FAST_LAT); end
      run_op(2'b11, 32'd5, 32'd0, 5'd7, r, l, w);
      checks++; if (r !== 32'd5) begin errors++; $display("FAIL remu_5_0 got %h exp 5", r); end
      run_op(2'b00, -32'sd5, 32'd0, 5'd7, r, l, w);
      checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_m5_0 got %h exp FFFFFFFF", r); end
      run_op(2'b10, -32'sd5, 32'd0, 5'd7, r, l, w);
      checks++; if (r !== 32'hFFFF_FFFB) begin errors++; $display("FAIL rem_m5_0 got %h exp FFFFFFFB", r); end
      run_op(2'b01, 32'd3, 32'd9, 5'd8, r, l, w);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL divu_3_9 got %h exp 0", r); end
      checks++; if (l !== FAST_LAT) begin errors++; $display("FAIL small_latency got %0d exp %0d", l, FAST_LAT); end
      run_op(2'b11, 32'd3, 32'd9, 5'd8, r, l, w);
      checks++; if (r !== 32'd3) begin errors++; $display("FAIL remu_3_9 got %h exp 3", r); end
   endtask

   task automatic test_hold;
      int l;
      op = 2'b00; data1 = 32'd100; data2 = -32'sd7; waddr = 5'd9; req_vld = 1'b1; rsp_rdy = 1'b0;
      @(posedge clk); #1;
      req_vld = 1'b0;
      l = 0;
      while (!rsp_vld && l < 200) begin @(posedge clk); #1; l++; end
      checks++; if (l !== 32) begin errors++; $display("FAIL hold_latency got %0d exp 32", l); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (rsp_vld !== 1'b1 || dout !== 32'hFFFF_FFF2 || waddr_o !== 5'd9 || req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable got vld=%b data=%h wa=%h rdy=%b exp 1/FFFFFFF2/09/0", rsp_vld, dout, waddr_o, req_rdy);
         end
      end
      rsp_rdy = 1'b1;
      @(posedge clk); #1;
      rsp_rdy = 1'b0;
      checks++; if (rsp_vld !== 1'b0 || busy !== 1'b0 || req_rdy !== 1'b1 || waddr_o !== 5'd0) begin
         errors++;
         $display("FAIL hold_release got vld=%b busy=%b rdy=%b wa=%h exp 0/0/1/00", rsp_vld, busy, req_rdy, waddr_o);
      end
   endtask

   task automatic test_flush;
      logic seen;
      op = 2'b01; data1 = 32'd100; data2 = 32'd7; waddr = 5'd4; req_vld = 1'b1;
      @(posedge clk); #1;
      req_vld = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++; if (busy !== 1'b0 || rsp_vld !== 1'b0) begin errors++; $display("FAIL flush_idle got busy=%b vld=%b exp 0/0", busy, rsp_vld); end
      checks++; if (dout !== 32'h0) begin errors++; $display("FAIL flush_data got %h exp 0", dout); end
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; seen |= rsp_vld; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_rsp got %b exp 0", seen); end
      req_vld = 1'b1; flush = 1'b1;
      #1;
      checks++; if (req_rdy !== 1'b0) begin errors++; $display("FAIL flush_req_rdy got %b exp 0", req_rdy); end
      @(posedge clk); #1;
      req_vld = 1'b0; flush = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_reject got busy=%b exp 0", busy); end
   endtask

   task automatic test_radix4_and_reset;
      int l;
      data1_2 = 16'hFFFF; data2_2 = 16'h0003; req_vld2 = 1'b1; rsp_rdy2 = 1'b0;
      @(posedge clk); #1;
      req_vld2 = 1'b0;
      l = 0;
      while (!rsp_vld2 && l < 100) begin @(posedge clk); #1; l++; end
      checks++; if (dout2 !== 16'h5555) begin errors++; $display("FAIL r4_divu got %h exp 5555", dout2); end
      checks++; if (l !== 8) begin errors++; $display("FAIL r4_latency got %0d exp 8", l); end
      checks++; if (waddr_o2 !== 5'd3) begin errors++; $display("FAIL r4_waddr got %h exp 03", waddr_o2); end
      rsp_rdy2 = 1'b1;
      @(posedge clk); #1;
      rsp_rdy2 = 1'b0;
      data1_2 = 16'd1000; data2_2 = 16'd3; req_vld2 = 1'b1;
      op = 2'b01; data1 = 32'd1000; data2 = 32'd3; req_vld = 1'b1;
      @(posedge clk); #1;
      req_vld2 = 1'b0; req_vld = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (busy2 !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b/%b exp 1/1", busy2, busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy2 !== 1'b0 || rsp_vld2 !== 1'b0 || dout2 !== 16'h0) begin
         errors++; $display("FAIL async_reset_r4 got busy=%b vld=%b data=%h exp 0/0/0000", busy2, rsp_vld2, dout2);
      end
      checks++; if (busy !== 1'b0 || rsp_vld !== 1'b0 || req_rdy !== 1'b1) begin
         errors++; $display("FAIL async_reset_r2 got busy=%b vld=%b rdy=%b exp 0/0/1", busy, rsp_vld, req_rdy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset;
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset;
      test_unsigned;
      test_signed;
      test_special;
      test_hold;
      test_flush;
      test_radix4_and_reset;
      test_reset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
